// File: rtl/pipe_ctrl.sv
// Pipeline sequencing controller: arbitrates redirect and hold requests into the
// PC register controls, buffers redirects across stalls, runs JTAG halt/drain/resume.
//
// state  | meaning
// RUN    | normal flow, redirects issued with zero latency
// STALL  | bus stall, hold PC, redirects buffered in pend_*
// DRAIN  | halt requested, hold IF/ID for DRAIN_CYCLES cycles
// HALTED | pipeline quiet, debugger may access the core
module pipe_ctrl #(
  parameter int          DRAIN_CYCLES = 3,
  parameter logic [31:0] RESET_ADDR   = 32'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ex_jump_req_i,
  input  logic [31:0] ex_jump_addr_i,
  input  logic        ex_hold_req_i,
  input  logic        int_req_i,
  input  logic [31:0] int_addr_i,
  input  logic        bus_hold_req_i,
  input  logic        jtag_halt_req_i,
  input  logic        jtag_reset_req_i,
  output logic        jump_flag_o,
  output logic [31:0] jump_addr_o,
  output logic [2:0]  hold_flag_o,
  output logic        jtag_reset_flag_o,
  output logic        halted_o,
  output logic        int_ack_o
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } state_t;

  localparam logic [2:0] HOLD_NONE = 3'd0;
  localparam logic [2:0] HOLD_PC   = 3'd1;
  localparam logic [2:0] HOLD_IF   = 3'd2;
  localparam logic [2:0] HOLD_ID   = 3'd3;
  localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

  state_t      r_state;
  state_t      w_next;
  logic        r_pend_valid;
  logic [31:0] r_pend_addr;
  logic        r_pend_is_int;
  logic [3:0]  r_drain_cnt;
  logic [3:0]  w_cnt_next;
  logic        r_jtag_reset_flag;
  logic        r_halted;

  logic        w_new_valid;
  logic [31:0] w_new_addr;
  logic        w_take_new;
  logic        w_eff_valid;
  logic [31:0] w_eff_addr;
  logic        w_eff_is_int;
  logic        w_issue;
  logic [2:0]  w_hold;

  // An interrupt displaces a buffered ex jump; nothing displaces a buffered interrupt.
  always_comb begin
    w_new_valid  = int_req_i | ex_jump_req_i;
    w_new_addr   = int_req_i ? int_addr_i : ex_jump_addr_i;
    w_take_new   = w_new_valid & (~r_pend_valid | (int_req_i & ~r_pend_is_int));
    w_eff_valid  = r_pend_valid | w_new_valid;
    w_eff_addr   = w_take_new ? w_new_addr : r_pend_addr;
    w_eff_is_int = w_take_new ? int_req_i : r_pend_is_int;
  end

  always_comb begin
    w_next     = r_state;
    w_cnt_next = r_drain_cnt;
    w_issue    = 1'b0;
    w_hold     = HOLD_NONE;
    case (r_state)
      RUN, STALL: begin
        if (bus_hold_req_i) begin
          w_hold = HOLD_PC;
          w_next = STALL;
        end else begin
          w_next = RUN;
          if (w_eff_valid) begin
            w_issue = 1'b1;
            w_hold  = HOLD_IF;
          end else if (ex_hold_req_i) begin
            w_hold = HOLD_ID;
          end
          if (jtag_halt_req_i) begin
            w_next     = DRAIN;
            w_cnt_next = 4'd0;
          end
        end
      end
      DRAIN: begin
        w_hold = HOLD_ID;
        if (!jtag_halt_req_i) begin
          w_next = RUN;
        end else if (r_drain_cnt == DRAIN_LAST) begin
          w_next = HALTED;
        end else begin
          w_cnt_next = r_drain_cnt + 4'd1;
        end
      end
      HALTED: begin
        w_hold = HOLD_ID;
        if (!jtag_halt_req_i) w_next = RUN;
      end
      default: w_next = RUN;
    endcase
    if (jtag_reset_req_i) begin
      w_next     = RUN;
      w_cnt_next = 4'd0;
      w_issue    = 1'b0;
      w_hold     = HOLD_NONE;
    end
  end

  always_comb begin
    jump_flag_o = rst & w_issue;
    jump_addr_o = (rst && w_issue) ? w_eff_addr : RESET_ADDR;
    hold_flag_o = rst ? w_hold : HOLD_NONE;
    int_ack_o   = rst & w_issue & w_eff_is_int;
  end

  assign jtag_reset_flag_o = r_jtag_reset_flag;
  assign halted_o          = r_halted;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state           <= RUN;
      r_drain_cnt       <= 4'd0;
      r_pend_valid      <= 1'b0;
      r_pend_addr       <= 32'h0;
      r_pend_is_int     <= 1'b0;
      r_jtag_reset_flag <= 1'b0;
      r_halted          <= 1'b0;
    end else begin
      r_state           <= w_next;
      r_drain_cnt       <= w_cnt_next;
      r_jtag_reset_flag <= jtag_reset_req_i;
      r_halted          <= (w_next == HALTED);
      if (jtag_reset_req_i || w_issue) begin
        r_pend_valid <= 1'b0;
      end else begin
        r_pend_valid  <= w_eff_valid;
        r_pend_addr   <= w_eff_addr;
        r_pend_is_int <= w_eff_is_int;
      end
    end
  end

endmodule

// File: tb/tb_pipe_ctrl.sv
// Scoreboard bench for pipe_ctrl: stimulus pushes per-cycle expectations from a
// queue-based reference model, a negedge monitor pops and compares.
module tb_pipe_ctrl;
  localparam int          N  = 3;
  localparam logic [31:0] RA = 32'h0;

  logic        clk;
  logic        rst;
  logic        ex_jump_req, ex_hold_req, int_req, bus_hold_req, jtag_halt_req, jtag_reset_req;
  logic [31:0] ex_jump_addr, int_addr;
  logic        jump_flag, jtag_reset_flag, halted, int_ack;
  logic [31:0] jump_addr;
  logic [2:0]  hold_flag;

  pipe_ctrl #(.DRAIN_CYCLES(N), .RESET_ADDR(RA)) dut (
    .clk(clk), .rst(rst),
    .ex_jump_req_i(ex_jump_req), .ex_jump_addr_i(ex_jump_addr), .ex_hold_req_i(ex_hold_req),
    .int_req_i(int_req), .int_addr_i(int_addr), .bus_hold_req_i(bus_hold_req),
    .jtag_halt_req_i(jtag_halt_req), .jtag_reset_req_i(jtag_reset_req),
    .jump_flag_o(jump_flag), .jump_addr_o(jump_addr), .hold_flag_o(hold_flag),
    .jtag_reset_flag_o(jtag_reset_flag), .halted_o(halted), .int_ack_o(int_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        jf;
    logic [31:0] ja;
    logic [2:0]  hf;
    logic        jrf;
    logic        h;
    logic        ack;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    bit          is_int;
  } redir_t;

  exp_t   exp_q[$];
  redir_t pend_q[$];
  int     n_checks = 0;
  int     n_pass   = 0;

  // Reference model: mode 0 = flowing (incl. bus stall), 1 = draining, 2 = halted.
  int m_mode    = 0;
  int m_drained = 0;
  bit m_halted  = 0;
  bit m_jrf     = 0;

  task automatic model_cycle(output exp_t e);
    redir_t nr;
    redir_t r;
    int     next_mode;
    e.jf  = 1'b0;
    e.ja  = RA;
    e.hf  = 3'd0;
    e.ack = 1'b0;
    e.jrf = m_jrf;
    e.h   = m_halted;
    if (!rst) begin
      e.jrf = 1'b0;
      e.h   = 1'b0;
      pend_q.delete();
      m_mode = 0; m_drained = 0; m_halted = 0; m_jrf = 0;
      return;
    end
    if (jtag_reset_req) begin
      pend_q.delete();
      m_mode = 0; m_drained = 0; m_halted = 0; m_jrf = 1;
      return;
    end
    if (int_req || ex_jump_req) begin
      nr.addr   = int_req ? int_addr : ex_jump_addr;
      nr.is_int = int_req;
      if (pend_q.size() == 0) pend_q.push_back(nr);
      else if (nr.is_int && !pend_q[0].is_int) pend_q[0] = nr;
    end
    next_mode = m_mode;
    if (m_mode == 0) begin
      if (bus_hold_req) begin
        e.hf = 3'd1;
      end else begin
        if (pend_q.size() > 0) begin
          r = pend_q.pop_front();
          e.jf = 1'b1; e.ja = r.addr; e.ack = r.is_int; e.hf = 3'd2;
        end else if (ex_hold_req) begin
          e.hf = 3'd3;
        end
        if (jtag_halt_req) begin
          next_mode = 1;
          m_drained = 0;
        end
      end
    end else begin
      e.hf = 3'd3;
      if (m_mode == 1) m_drained++;
      if (!jtag_halt_req) next_mode = 0;
      else if (m_mode == 1 && m_drained >= N) next_mode = 2;
    end
    m_mode   = next_mode;
    m_halted = (next_mode == 2);
    m_jrf    = 0;
  endtask

  task automatic step(input bit r, input bit bus, input bit exh, input bit exj,
                      input logic [31:0] exa, input bit intr, input logic [31:0] ia,
                      input bit hlt, input bit jres);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; bus_hold_req = bus; ex_hold_req = exh; ex_jump_req = exj; ex_jump_addr = exa;
    int_req = intr; int_addr = ia; jtag_halt_req = hlt; jtag_reset_req = jres;
    model_cycle(e);
    exp_q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
  endtask

  // Asserts reset between edges and checks the outputs respond without a clock.
  task automatic reset_mid();
    exp_t e;
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    n_checks++;
    if (jump_flag !== 1'b0 || jump_addr !== RA || hold_flag !== 3'd0 || int_ack !== 1'b0 ||
        jtag_reset_flag !== 1'b0 || halted !== 1'b0)
      $display("FAIL async_reset: got jf=%0b ja=%h hf=%0d ack=%0b jrf=%0b h=%0b, required all 0 and ja=%h",
               jump_flag, jump_addr, hold_flag, int_ack, jtag_reset_flag, halted, RA);
    else n_pass++;
    model_cycle(e);
    exp_q.push_back(e);
  endtask

  always @(negedge clk) begin
    exp_t e;
    exp_t got;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      got = {jump_flag, jump_addr, hold_flag, jtag_reset_flag, halted, int_ack};
      n_checks++;
      if (got !== e)
        $display("FAIL cycle_outputs t=%0t: got jf=%0b ja=%h hf=%0d jrf=%0b h=%0b ack=%0b, required jf=%0b ja=%h hf=%0d jrf=%0b h=%0b ack=%0b",
                 $time, got.jf, got.ja, got.hf, got.jrf, got.h, got.ack,
                 e.jf, e.ja, e.hf, e.jrf, e.h, e.ack);
      else n_pass++;
    end
  end

  initial begin
    bit hlt_lvl;
    rst = 1'b1;
    ex_jump_req = 0; ex_hold_req = 0; int_req = 0; bus_hold_req = 0;
    jtag_halt_req = 0; jtag_reset_req = 0; ex_jump_addr = 0; int_addr = 0;
    #2 rst = 1'b0;
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(2);
    // plain jump, then simultaneous ex jump and interrupt
    step(1, 0, 0, 1, 32'h0000_0100, 0, 32'h0, 0, 0);
    idle(1);
    step(1, 0, 0, 1, 32'h0000_0200, 1, 32'h0000_0008, 0, 0);
    idle(1);
    step(1, 0, 1, 0, 32'h0, 0, 32'h0, 0, 0);
    // stall buffering with interrupt displacing the ex jump
    step(1, 1, 0, 1, 32'h0000_0300, 0, 32'h0, 0, 0);
    step(1, 1, 0, 0, 32'h0, 1, 32'h0000_0040, 0, 0);
    step(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    step(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(3);
    // halt / drain / resume
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    idle(3);
    // halt dropped mid-drain with a buffered redirect
    step(1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    step(1, 0, 0, 1, 32'h0000_0600, 0, 32'h0, 1, 0);
    idle(3);
    // jtag reset while a redirect is buffered in a stall
    step(1, 1, 0, 1, 32'h0000_0500, 0, 32'h0, 0, 0);
    step(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 1);
    step(1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(4);
    // asynchronous reset while halted
    for (int i = 0; i < 6; i++) step(1, 0, 0, 0, 32'h0, 0, 32'h0, 1, 0);
    reset_mid();
    step(0, 0, 0, 0, 32'h0, 0, 32'h0, 0, 0);
    idle(2);
    // randomized traffic
    hlt_lvl = 0;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 11) == 0) hlt_lvl = !hlt_lvl;
      step($urandom_range(0, 499) != 0,
           $urandom_range(0, 9) < 3,
           $urandom_range(0, 9) < 2,
           $urandom_range(0, 9) < 2, $urandom(),
           $urandom_range(0, 9) < 1, $urandom(),
           hlt_lvl,
           $urandom_range(0, 39) == 0);
    end
    idle(2);
    @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      n_checks++;
      $display("FAIL scoreboard_drain: got %0d entries left, required 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pipe_ctrl.md
Name: pipe_ctrl

Overview:
Pipeline sequencing controller that drives the PC register's jump_flag_i, jump_addr_i and hold_flag_i inputs. It arbitrates redirect requests from the execute stage and the interrupt controller, and hold requests from execute, the bus and the JTAG debug module. A redirect that arrives during a bus stall is buffered and replayed when the stall clears. It also runs the JTAG halt/drain/resume sequence.

Parameters:
- DRAIN_CYCLES, 3, cycles to hold IF/ID after a halt request before reporting halted (1..15)
- RESET_ADDR, 32'h0, value driven on jump_addr_o during and after reset

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous active-low reset
- ex_jump_req_i  in  1  execute-stage branch/jump redirect
- ex_jump_addr_i  in  32  execute redirect target
- ex_hold_req_i  in  1  execute multi-cycle op (div) stall
- int_req_i  in  1  interrupt redirect request
- int_addr_i  in  32  interrupt/trap target
- bus_hold_req_i  in  1  bus arbiter stall
- jtag_halt_req_i  in  1  debugger halt request (level)
- jtag_reset_req_i  in  1  debugger core reset (pulse)
- jump_flag_o  out  1  to PC jump_flag_i
- jump_addr_o  out  32  to PC jump_addr_i
- hold_flag_o  out  3  to PC hold_flag_i: 0 none, 1 PC, 2 IF, 3 ID
- jtag_reset_flag_o  out  1  to PC jtag_reset_flag_i
- halted_o  out  1  core halted, debugger may access
- int_ack_o  out  1  one-cycle pulse when the interrupt redirect is issued

Behaviour:
- Reset (rst=0, async): state=RUN, pend_valid=0, drain_cnt=0, jtag_reset_flag_o=0, halted_o=0. Combinational outputs are forced to jump_flag_o=0, jump_addr_o=RESET_ADDR, hold_flag_o=0, int_ack_o=0.
- jtag_reset_flag_o is registered: it equals jtag_reset_req_i delayed by one cycle. A jtag reset request also clears pend_valid and returns the state to RUN (synchronous, highest priority).
- States: RUN, STALL, DRAIN, HALTED.
- Redirect select (combinational): int_req_i beats ex_jump_req_i. When both are present, the interrupt wins; the ex jump is dropped (the trap handler's return reissues it).
- RUN:
  - bus_hold_req_i=0 with a redirect present: jump_flag_o=1 and jump_addr_o=selected target in the same cycle (zero latency). hold_flag_o=2 (flush IF). int_ack_o=1 if the interrupt was selected.
  - bus_hold_req_i=1 with a redirect present: latch target into pend_addr, pend_valid=1, pend_is_int; go to STALL. Outputs this cycle: jump_flag_o=0, hold_flag_o=1.
  - bus_hold_req_i=1 with no redirect: go to STALL, hold_flag_o=1.
  - ex_hold_req_i=1 with no redirect: hold_flag_o=3, stay in RUN.
  - jtag_halt_req_i=1: go to DRAIN with drain_cnt=0. A redirect in the same cycle is still issued first.
- STALL:
  - hold_flag_o=1, jump_flag_o=0.
  - A new redirect while pend_valid=0 is latched. While pend_valid=1, an interrupt overwrites a pending ex jump; an ex jump never overwrites a pending interrupt.
  - On bus_hold_req_i=0: if pend_valid, then jump_flag_o=1, jump_addr_o=pend_addr, hold_flag_o=2, int_ack_o=pend_is_int, clear pend_valid. Return to RUN in the same cycle.
- DRAIN:
  - hold_flag_o=3, jump_flag_o=0, drain_cnt increments each cycle.
  - Redirects are latched as in STALL.
  - At drain_cnt==DRAIN_CYCLES-1, go to HALTED.
  - If jtag_halt_req_i drops first, return to RUN and replay any pending redirect.
- HALTED:
  - hold_flag_o=3, halted_o=1 (registered, asserted the first cycle in HALTED).
  - On jtag_halt_req_i=0: halted_o=0 next cycle, go to RUN, replay pending redirect on entry.
- Bus hold in DRAIN/HALTED does not change state: hold_flag_o stays 3, which is at least Hold_Pc.
- jump_flag_o is never asserted while hold_flag_o==1 or 3.
- Target addresses pass through unmodified; no alignment checking.

Test Plan:
- Reset: rst=0 asynchronously mid-cycle -> all outputs immediately 0 and jump_addr_o=RESET_ADDR; first edge after rst=1 shows state RUN.
- Plain jump: RUN, ex_jump_req_i=1, addr=32'h0000_0100 -> same cycle jump_flag_o=1, jump_addr_o=32'h100, hold_flag_o=2; PC reads 32'h100 next edge.
- Simultaneous: ex_jump (32'h200) and int_req (32'h8) -> jump_addr_o=32'h8, int_ack_o=1 for one cycle, ex target never emitted.
- Stall buffering: bus_hold 4 cycles; ex_jump 32'h300 in cycle 1, int 32'h40 in cycle 2 -> hold_flag_o=1 for 4 cycles; on release jump_flag_o=1, addr 32'h40, int_ack_o=1, one pulse only.
- Halt: jtag_halt_req_i=1 with DRAIN_CYCLES=3 -> hold_flag_o=3 for 3 cycles, then halted_o=1; deassert -> halted_o=0 next cycle, hold_flag_o=0.
- JTAG reset during STALL with pend_valid=1 -> jtag_reset_flag_o=1 one cycle later; pend dropped, no later jump_flag_o pulse.
